// File: rtl/sb_tx_packet_framer_gen_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sb_pkg
// Description : Shared constants, message record and FSM states for the SB TX framer.
// Revision    : 1.0
// ============================================================================
package sb_pkg;

  localparam int SB_PHASE_W         = 64;
  localparam int SB_MAX_DATA_PHASES = 2;
  localparam int SB_LEN_W           = $clog2(SB_MAX_DATA_PHASES + 1);
  localparam int SB_OPC_LSB         = 14;
  localparam int SB_OPC_W           = 4;
  localparam int SB_TIMEOUT_OPC     = 5;

  typedef struct packed {
    logic [SB_PHASE_W-3:0]                  header;
    logic [SB_PHASE_W*SB_MAX_DATA_PHASES-1:0] data;
    logic [SB_LEN_W-1:0]                    len;
    logic                                   cp;
    logic                                   dp;
  } sb_msg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } framer_state_e;

endpackage : sb_pkg
`default_nettype wire

// File: rtl/sb_tx_packet_framer_gen_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sb_tx_msg_fifo
// Description : Power-of-two deep message queue; push/pop guarded against full/empty.
// Revision    : 1.0
// ============================================================================
module sb_tx_msg_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : sb_tx_msg_fifo
`default_nettype wire

// File: rtl/sb_tx_packet_framer_gen.sv
`default_nettype none
// ============================================================================
// Module      : sb_tx_packet_framer_gen
// Description : Queued sideband TX framer: header phase {dp,cp,header} then data phases.
// Revision    : 1.0
// ============================================================================
module sb_tx_packet_framer_gen
  import sb_pkg::*;
#(
  parameter  int PHASE_W         = SB_PHASE_W,
  parameter  int MAX_DATA_PHASES = SB_MAX_DATA_PHASES,
  parameter  int QUEUE_DEPTH     = 2,
  parameter  int OPC_LSB         = SB_OPC_LSB,
  parameter  int TIMEOUT_OPC     = SB_TIMEOUT_OPC,
  localparam int LEN_W           = $clog2(MAX_DATA_PHASES + 1)
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_msg_valid,
  output logic                               o_msg_ready,
  input  logic [PHASE_W-3:0]                 i_header,
  input  logic [PHASE_W*MAX_DATA_PHASES-1:0] i_data,
  input  logic [LEN_W-1:0]                   i_data_len,
  input  logic                               i_ser_done,
  output logic [PHASE_W-1:0]                 o_framed_packet_phase,
  output logic                               o_packet_valid,
  output logic                               o_timeout_ctr_start,
  output logic                               o_busy,
  output logic                               o_len_err
);

  typedef struct packed {
    logic [PHASE_W-3:0]                 header;
    logic [PHASE_W*MAX_DATA_PHASES-1:0] data;
    logic [LEN_W-1:0]                   len;
    logic                               cp;
    logic                               dp;
  } msg_t;

  localparam int QAW = $clog2(QUEUE_DEPTH);

  msg_t               w_push_msg, w_head, r_inflight;
  logic               w_full, w_empty, w_push, w_pop, w_load, w_issue;
  logic [QAW:0]       w_count;
  logic               w_len_ovf, w_dp;
  logic [LEN_W-1:0]   w_len;
  framer_state_e      r_state, w_state_next;
  logic [LEN_W-1:0]   r_k, w_k_next;
  logic [PHASE_W-1:0] r_phase, w_phase_next;
  logic               r_valid, w_valid_next, r_tout, w_tout_next, r_len_err;

  assign w_push    = i_msg_valid && !w_full;
  assign w_issue   = i_ser_done && !r_valid;
  assign w_len_ovf = (i_data_len > LEN_W'(MAX_DATA_PHASES));
  assign w_len     = w_len_ovf ? LEN_W'(MAX_DATA_PHASES) : i_data_len;

  // Data parity covers only the phases that will actually be sent.
  always_comb begin
    w_dp = 1'b0;
    for (int k = 0; k < MAX_DATA_PHASES; k++) begin
      if (k < int'(w_len)) w_dp = w_dp ^ (^i_data[k*PHASE_W +: PHASE_W]);
    end
  end

  always_comb begin
    w_push_msg.header = i_header;
    w_push_msg.data   = i_data;
    w_push_msg.len    = w_len;
    w_push_msg.cp     = ^i_header;
    w_push_msg.dp     = w_dp;
  end

  sb_tx_msg_fifo #(
    .WIDTH ($bits(msg_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_push_msg),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_valid_next = 1'b0;
    w_tout_next  = 1'b0;
    w_phase_next = r_phase;
    w_k_next     = r_k;
    case (r_state)
      IDLE: begin
        if (!w_empty && w_issue) begin
          w_pop        = 1'b1;
          w_load       = 1'b1;
          w_valid_next = 1'b1;
          w_phase_next = {w_head.dp, w_head.cp, w_head.header};
          w_tout_next  = (w_head.header[OPC_LSB +: SB_OPC_W] == SB_OPC_W'(TIMEOUT_OPC));
          w_k_next     = '0;
          w_state_next = (w_head.len != '0) ? DATA : IDLE;
        end
      end
      // Entries always pop in IDLE, so the holding state is never entered.
      HDR: w_state_next = IDLE;
      DATA: begin
        if (w_issue) begin
          w_valid_next = 1'b1;
          w_phase_next = r_inflight.data[int'(r_k)*PHASE_W +: PHASE_W];
          w_k_next     = r_k + LEN_W'(1);
          if (r_k == r_inflight.len - LEN_W'(1)) w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_phase    <= '0;
      r_valid    <= 1'b0;
      r_tout     <= 1'b0;
      r_len_err  <= 1'b0;
      r_inflight <= '0;
    end else begin
      r_state <= w_state_next;
      r_k     <= w_k_next;
      r_phase <= w_phase_next;
      r_valid <= w_valid_next;
      r_tout  <= w_tout_next;
      if (w_load) r_inflight <= w_head;
      if (w_push && w_len_ovf) r_len_err <= 1'b1;
    end
  end

  assign o_msg_ready           = !w_full;
  assign o_framed_packet_phase = r_phase;
  assign o_packet_valid        = r_valid;
  assign o_timeout_ctr_start   = r_tout;
  assign o_busy                = (w_count != '0) || (r_state != IDLE);
  assign o_len_err             = r_len_err;

endmodule : sb_tx_packet_framer_gen
`default_nettype wire

// File: tb/tb_sb_tx_packet_framer_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sb_tx_packet_framer_gen
// Description : Directed self-checking bench for sb_tx_packet_framer_gen.
// Revision    : 1.1
// ============================================================================
module tb_sb_tx_packet_framer_gen;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         msg_valid;
    logic         msg_ready;
    logic [61:0]  header;
    logic [127:0] data;
    logic [1:0]   data_len;
    logic         ser_done;
    logic [63:0]  phase;
    logic         pkt_valid;
    logic         tout_start;
    logic         busy;
    logic         len_err;

    int checks   = 0;
    int failures = 0;
    int n;
    int pulses;
    logic got;

    always #5 clk = ~clk;

    sb_tx_packet_framer_gen dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_msg_valid           (msg_valid),
        .o_msg_ready           (msg_ready),
        .i_header              (header),
        .i_data                (data),
        .i_data_len            (data_len),
        .i_ser_done            (ser_done),
        .o_framed_packet_phase (phase),
        .o_packet_valid        (pkt_valid),
        .o_timeout_ctr_start   (tout_start),
        .o_busy                (busy),
        .o_len_err             (len_err)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [61:0] h, input logic [127:0] d, input logic [1:0] l);
        msg_valid = 1'b1;
        header    = h;
        data      = d;
        data_len  = l;
        tick();
        msg_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int max_cyc, output int cyc, output logic seen);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < max_cyc) begin
            tick();
            cyc++;
            if (pkt_valid) seen = 1'b1;
        end
    endtask

    task automatic quiet(input int cyc, output int cnt);
        cnt = 0;
        for (int i = 0; i < cyc; i++) begin
            tick();
            if (pkt_valid) cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; msg_valid = 1'b0; header = '0; data = '0; data_len = '0; ser_done = 1'b0;
        repeat (3) tick();
        check("rst_valid", pkt_valid, 1'b0);
        check("rst_phase", phase, 64'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", msg_ready, 1'b1);
        check("rst_len_err", len_err, 1'b0);
        check("rst_tout", tout_start, 1'b0);
        rst_n = 1'b1;
        tick();

        // 1: header only, cp=1
        ser_done = 1'b1;
        push(62'h1, '0, 2'd0);
        wait_pulse(8, n, got);
        check("t1_got", got, 1'b1);
        check("t1_latency", n, 1);
        check("t1_phase", phase, 64'h4000_0000_0000_0001);
        check("t1_tout", tout_start, 1'b0);
        check("t1_busy", busy, 1'b0);

        // 2: two data phases, dp=1
        push(62'h3, {64'hAAAA_AAAA_AAAA_AAAA, 64'h1}, 2'd2);
        wait_pulse(8, n, got);
        check("t2_hdr", phase, 64'h8000_0000_0000_0003);
        check("t2_busy_mid", busy, 1'b1);
        wait_pulse(8, n, got);
        check("t2_gap0", n, 2);
        check("t2_d0", phase, 64'h1);
        wait_pulse(8, n, got);
        check("t2_gap1", n, 2);
        check("t2_d1", phase, 64'hAAAA_AAAA_AAAA_AAAA);
        check("t2_busy_end", busy, 1'b0);

        // 3: timeout opcode 5 arms on header only; opcode 4 never
        push(62'h14000, {64'h0, 64'h3}, 2'd1);
        wait_pulse(8, n, got);
        check("t3_hdr", phase, 64'h0000_0000_0001_4000);
        check("t3_tout_hdr", tout_start, 1'b1);
        wait_pulse(8, n, got);
        check("t3_d0", phase, 64'h3);
        check("t3_tout_data", tout_start, 1'b0);
        push(62'h10000, '0, 2'd0);
        wait_pulse(8, n, got);
        check("t3_hdr4", phase, 64'h4000_0000_0001_0000);
        check("t3_tout_op4", tout_start, 1'b0);

        // 4: fill queue with serializer stalled; third push refused
        ser_done = 1'b0;
        push(62'h11, '0, 2'd0);
        check("t4_ready1", msg_ready, 1'b1);
        push(62'h7, '0, 2'd0);
        check("t4_ready_full", msg_ready, 1'b0);
        push(62'h22, '0, 2'd0);
        check("t4_ready_still", msg_ready, 1'b0);
        check("t4_busy", busy, 1'b1);
        check("t4_no_pulse", pkt_valid, 1'b0);
        ser_done = 1'b1;
        wait_pulse(8, n, got);
        check("t4_a", phase, 64'h0000_0000_0000_0011);
        wait_pulse(8, n, got);
        check("t4_b", phase, 64'h4000_0000_0000_0007);
        quiet(6, pulses);
        check("t4_c_dropped", pulses, 0);
        check("t4_busy_end", busy, 1'b0);

        // length overflow clamps to two phases and sets the sticky flag
        push(62'h0, {64'h0, 64'h1}, 2'd3);
        check("len_err_set", len_err, 1'b1);
        wait_pulse(8, n, got);
        check("len_hdr", phase, 64'h8000_0000_0000_0000);
        wait_pulse(8, n, got);
        check("len_d0", phase, 64'h1);
        wait_pulse(8, n, got);
        check("len_d1", phase, 64'h0);
        quiet(6, pulses);
        check("len_clamped", pulses, 0);
        check("len_err_sticky", len_err, 1'b1);

        // 5: serializer stalls between data phases
        push(62'h0, {64'hBEEF, 64'hCAFE}, 2'd2);
        wait_pulse(8, n, got);
        check("t5_hdr", phase, 64'h0);
        ser_done = 1'b0;
        quiet(5, pulses);
        check("t5_stall0", pulses, 0);
        ser_done = 1'b1;
        wait_pulse(8, n, got);
        check("t5_d0", phase, 64'hCAFE);
        ser_done = 1'b0;
        quiet(4, pulses);
        check("t5_stall1", pulses, 0);
        ser_done = 1'b1;
        wait_pulse(8, n, got);
        check("t5_d1", phase, 64'hBEEF);
        quiet(6, pulses);
        check("t5_no_dup", pulses, 0);

        // 6: reset mid-message with another message queued
        push(62'h5, {64'h9, 64'h8}, 2'd2);
        wait_pulse(8, n, got);
        wait_pulse(8, n, got);
        check("t6_d0", phase, 64'h8);
        push(62'h6, '0, 2'd0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", pkt_valid, 1'b0);
        check("t6_rst_phase", phase, 64'h0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_len_err", len_err, 1'b0);
        tick();
        rst_n = 1'b1;
        quiet(8, pulses);
        check("t6_no_pulse", pulses, 0);
        check("t6_busy", busy, 1'b0);
        check("t6_ready", msg_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sb_tx_packet_framer_gen
`default_nettype wire
